// File: rtl/csm_pkg.sv
// Shared definitions for the storage/compute datapath and its controller.
// - opcode_e : operation encoding shared with the controller FSM
// - ARITH_*  : arith_op strobe values
// - DEFAULT_*: default datapath geometry
package csm_pkg;

  typedef enum logic [1:0] {
    OP_RD  = 2'b00,
    OP_WR  = 2'b01,
    OP_ADD = 2'b10,
    OP_SUB = 2'b11
  } opcode_e;

  localparam logic ARITH_ADD = 1'b0;
  localparam logic ARITH_SUB = 1'b1;

  localparam int unsigned DEFAULT_WIDTH = 8;
  localparam int unsigned DEFAULT_DEPTH = 16;

endpackage

// File: rtl/csm_addsub.sv
// Combinational WIDTH-bit adder/subtractor.
// Ports:
//   a_i, b_i     operands (result is a_i +/- b_i)
//   sub_i        ARITH_ADD or ARITH_SUB
//   result_o     low WIDTH bits of the result
//   carry_o      carry out (add) or borrow (sub, set when a_i < b_i unsigned)
//   overflow_o   two's-complement signed overflow
module csm_addsub
  import csm_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             sub_i,
  output logic [WIDTH-1:0] result_o,
  output logic             carry_o,
  output logic             overflow_o
);

  logic [WIDTH:0] ext;
  logic           b_eff_msb;

  always_comb begin
    ext = '0;
    if (sub_i == ARITH_SUB) begin
      // Bit WIDTH of the extended difference is the borrow.
      ext = {1'b0, a_i} - {1'b0, b_i};
    end else begin
      ext = {1'b0, a_i} + {1'b0, b_i};
    end
  end

  assign result_o = ext[WIDTH-1:0];
  assign carry_o  = ext[WIDTH];

  // Subtraction adds the complement of b, so its sign flips for the overflow test.
  assign b_eff_msb  = (sub_i == ARITH_SUB) ? ~b_i[WIDTH-1] : b_i[WIDTH-1];
  assign overflow_o = (a_i[WIDTH-1] == b_eff_msb) && (result_o[WIDTH-1] != a_i[WIDTH-1]);

endmodule

// File: rtl/storage_compute_datapath.sv
// Responder side of the operation-controller interface: a register-file memory
// with one shared read/write port (port 1) and one read port (port 2), operand
// registers A/B and an add/sub unit whose result is written back to memory.
// Ports:
//   clk, rst_n                   clock (rising edge), async active-low reset
//   RD_en1, RD_en2, WR_en1       port strobes from the controller
//   mux1                         port-1 address: 0 = rd_addr1, 1 = wr_addr
//   mux2                         0 = plain memory op, 1 = arithmetic op
//   arith_op                     0 = add, 1 = subtract (A - B)
//   rd_addr1, rd_addr2, wr_addr  addresses
//   data_in                      external write data
//   data_out, out_valid          registered read data and its one-cycle pulse
//   carry, overflow              flags of the last arithmetic write-back
//   proto_err                    sticky protocol-violation flag
module storage_compute_datapath
  import csm_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned DEPTH = DEFAULT_DEPTH,
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             RD_en1,
  input  logic             RD_en2,
  input  logic             WR_en1,
  input  logic             mux1,
  input  logic             mux2,
  input  logic             arith_op,
  input  logic [AW-1:0]    rd_addr1,
  input  logic [AW-1:0]    rd_addr2,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             out_valid,
  output logic             carry,
  output logic             overflow,
  output logic             proto_err
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] data_out_q;
  logic             out_valid_q, carry_q, overflow_q, proto_err_q;

  logic [AW-1:0]    addr1;
  logic [WIDTH-1:0] rd_data1, rd_data2, wr_data;
  logic             wr_ok, rd1_ok, plain_rd, load_a, load_b, arith_wb, err_set;
  logic [WIDTH-1:0] alu_result;
  logic             alu_carry, alu_overflow;

  // Out-of-range addresses only exist when DEPTH is not a power of two.
  function automatic logic in_range(logic [AW-1:0] addr);
    return 32'(addr) < DEPTH;
  endfunction

  assign addr1 = mux1 ? wr_addr : rd_addr1;

  assign rd_data1 = in_range(addr1)    ? mem_q[addr1]    : '0;
  assign rd_data2 = in_range(rd_addr2) ? mem_q[rd_addr2] : '0;

  // Port 1 is shared: a simultaneous write wins and the read is dropped.
  assign wr_ok    = WR_en1 & mux1;
  assign rd1_ok   = RD_en1 & ~WR_en1;
  assign plain_rd = rd1_ok & ~mux2;
  assign load_a   = rd1_ok & RD_en2 & mux2;
  assign load_b   = RD_en2 & mux2;
  assign arith_wb = wr_ok & mux2;

  assign err_set = (RD_en1 & WR_en1) | (WR_en1 & ~mux1) | (RD_en2 & ~mux2);

  csm_addsub #(
    .WIDTH (WIDTH)
  ) u_addsub (
    .a_i        (a_q),
    .b_i        (b_q),
    .sub_i      (arith_op),
    .result_o   (alu_result),
    .carry_o    (alu_carry),
    .overflow_o (alu_overflow)
  );

  assign wr_data = mux2 ? alu_result : data_in;

  // Memory; port-2 reads see pre-write contents because the write lands at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_ok && in_range(wr_addr)) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q         <= '0;
      b_q         <= '0;
      data_out_q  <= '0;
      out_valid_q <= 1'b0;
      carry_q     <= 1'b0;
      overflow_q  <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      out_valid_q <= plain_rd;
      if (plain_rd) begin
        data_out_q <= rd_data1;
      end
      if (load_a) begin
        a_q <= rd_data1;
      end
      if (load_b) begin
        b_q <= rd_data2;
      end
      if (arith_wb) begin
        carry_q    <= alu_carry;
        overflow_q <= alu_overflow;
      end
      if (err_set) begin
        proto_err_q <= 1'b1;
      end
    end
  end

  assign data_out  = data_out_q;
  assign out_valid = out_valid_q;
  assign carry     = carry_q;
  assign overflow  = overflow_q;
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_storage_compute_datapath.sv
// Directed, table-driven bench for storage_compute_datapath (WIDTH=8, DEPTH=16).
module tb_storage_compute_datapath;

  logic       clk, rst_n;
  logic       RD_en1, RD_en2, WR_en1, mux1, mux2, arith_op;
  logic [3:0] rd_addr1, rd_addr2, wr_addr;
  logic [7:0] data_in, data_out;
  logic       out_valid, carry, overflow, proto_err;

  int checks = 0;
  int errors = 0;

  storage_compute_datapath #(
    .WIDTH (8),
    .DEPTH (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .RD_en1    (RD_en1),
    .RD_en2    (RD_en2),
    .WR_en1    (WR_en1),
    .mux1      (mux1),
    .mux2      (mux2),
    .arith_op  (arith_op),
    .rd_addr1  (rd_addr1),
    .rd_addr2  (rd_addr2),
    .wr_addr   (wr_addr),
    .data_in   (data_in),
    .data_out  (data_out),
    .out_valid (out_valid),
    .carry     (carry),
    .overflow  (overflow),
    .proto_err (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rd1, rd2, wr1, m1, m2, op;
    logic [3:0] ra1, ra2, wa;
    logic [7:0] din;
    logic       chk_d;
    logic [7:0] e_d;
    logic       e_v;
    logic       chk_f;
    logic       e_c, e_o;
    logic       e_err;
    string      name;
  } vec_t;

  vec_t vecs[$];
  logic cur_err = 1'b0;

  function automatic vec_t v_base(string name);
    vec_t v;
    v.rd1 = 0; v.rd2 = 0; v.wr1 = 0; v.m1 = 0; v.m2 = 0; v.op = 0;
    v.ra1 = 0; v.ra2 = 0; v.wa = 0; v.din = 0;
    v.chk_d = 0; v.e_d = 0; v.e_v = 0; v.chk_f = 0; v.e_c = 0; v.e_o = 0;
    v.e_err = cur_err; v.name = name;
    return v;
  endfunction

  function automatic vec_t v_idle(string name, logic chk, logic [7:0] d);
    vec_t v = v_base(name);
    v.chk_d = chk; v.e_d = d;
    return v;
  endfunction

  function automatic vec_t v_wr(string name, logic [3:0] a, logic [7:0] d);
    vec_t v = v_base(name);
    v.wr1 = 1; v.m1 = 1; v.wa = a; v.din = d;
    return v;
  endfunction

  function automatic vec_t v_rd(string name, logic [3:0] a, logic [7:0] e);
    vec_t v = v_base(name);
    v.rd1 = 1; v.ra1 = a; v.chk_d = 1; v.e_d = e; v.e_v = 1;
    return v;
  endfunction

  function automatic vec_t v_ar(string name, logic [3:0] a, logic [3:0] b, logic [7:0] keep);
    vec_t v = v_base(name);
    v.rd1 = 1; v.rd2 = 1; v.m2 = 1; v.ra1 = a; v.ra2 = b; v.chk_d = 1; v.e_d = keep;
    return v;
  endfunction

  function automatic vec_t v_wb(string name, logic [3:0] a, logic op, logic c, logic o);
    vec_t v = v_base(name);
    v.wr1 = 1; v.m1 = 1; v.m2 = 1; v.op = op; v.wa = a; v.chk_f = 1; v.e_c = c; v.e_o = o;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    RD_en1 = v.rd1; RD_en2 = v.rd2; WR_en1 = v.wr1; mux1 = v.m1; mux2 = v.m2;
    arith_op = v.op; rd_addr1 = v.ra1; rd_addr2 = v.ra2; wr_addr = v.wa; data_in = v.din;
  endtask

  // Drive at a falling edge, let one rising edge pass, compare at the next falling edge.
  task automatic apply(vec_t v);
    drive(v);
    @(negedge clk);
    check({v.name, " out_valid"}, 32'(out_valid), 32'(v.e_v));
    check({v.name, " proto_err"}, 32'(proto_err), 32'(v.e_err));
    if (v.chk_d) check({v.name, " data_out"}, 32'(data_out), 32'(v.e_d));
    if (v.chk_f) begin
      check({v.name, " carry"}, 32'(carry), 32'(v.e_c));
      check({v.name, " overflow"}, 32'(overflow), 32'(v.e_o));
    end
  endtask

  initial begin
    vec_t v;
    drive(v_base("init"));
    rst_n = 1'b0;
    #12;
    check("reset data_out", 32'(data_out), 32'h0);
    check("reset out_valid", 32'(out_valid), 32'h0);
    check("reset flags", {29'h0, carry, overflow, proto_err}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    vecs.push_back(v_idle("idle0", 1, 8'h00));
    vecs.push_back(v_wr("wr5", 4'd5, 8'h3C));
    vecs.push_back(v_rd("rd5", 4'd5, 8'h3C));
    vecs.push_back(v_idle("idle_after_rd5", 1, 8'h3C));
    vecs.push_back(v_wr("wr1", 4'd1, 8'h70));
    vecs.push_back(v_wr("wr2", 4'd2, 8'h20));
    vecs.push_back(v_ar("add_rd", 4'd1, 4'd2, 8'h3C));
    vecs.push_back(v_wb("add_wb3", 4'd3, 1'b0, 1'b0, 1'b1));
    v = v_rd("rd3", 4'd3, 8'h90); v.chk_f = 1; v.e_c = 0; v.e_o = 1;
    vecs.push_back(v);
    vecs.push_back(v_wr("wr1b", 4'd1, 8'h05));
    vecs.push_back(v_wr("wr2b", 4'd2, 8'h07));
    vecs.push_back(v_ar("sub_rd", 4'd1, 4'd2, 8'h90));
    vecs.push_back(v_wb("sub_wb1", 4'd1, 1'b1, 1'b1, 1'b0));
    vecs.push_back(v_rd("rd1", 4'd1, 8'hFE));
    vecs.push_back(v_wr("wr4", 4'd4, 8'hFF));
    vecs.push_back(v_wr("wr6", 4'd6, 8'h01));
    vecs.push_back(v_ar("add2_rd", 4'd4, 4'd6, 8'hFE));
    vecs.push_back(v_wb("add2_wb4", 4'd4, 1'b0, 1'b1, 1'b0));
    vecs.push_back(v_rd("rd4", 4'd4, 8'h00));
    cur_err = 1'b1;
    v = v_wr("rd_wr_clash", 4'd7, 8'hAA); v.rd1 = 1; v.ra1 = 4'd7; v.chk_d = 1; v.e_d = 8'h00;
    vecs.push_back(v);
    vecs.push_back(v_rd("rd7", 4'd7, 8'hAA));
    vecs.push_back(v_idle("idle_err", 1, 8'hAA));
    v = v_wr("wr_mux1_0", 4'd5, 8'h11); v.m1 = 0; v.ra1 = 4'd9;
    vecs.push_back(v);
    vecs.push_back(v_rd("rd5_kept", 4'd5, 8'h3C));
    v = v_idle("rd2_mux2_0", 1, 8'h3C); v.rd2 = 1; v.ra2 = 4'd5;
    vecs.push_back(v);

    foreach (vecs[i]) apply(vecs[i]);

    // Reset between an arithmetic read and its write-back.
    cur_err = 1'b1;
    apply(v_wr("wr8", 4'd8, 8'h40));
    apply(v_ar("mid_rd", 4'd8, 4'd8, 8'h3C));
    rst_n = 1'b0;
    #1;
    check("midrst data_out", 32'(data_out), 32'h0);
    check("midrst flags", {28'h0, out_valid, carry, overflow, proto_err}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cur_err = 1'b0;
    // A and B were cleared, so a write-back now yields 0 and is not an error.
    apply(v_wb("wb_after_rst", 4'd9, 1'b0, 1'b0, 1'b0));
    for (int i = 0; i < 16; i++) begin
      apply(v_rd($sformatf("rd_zero%0d", i), 4'(i), 8'h00));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/storage_compute_datapath.md
Name: storage_compute_datapath

Overview:
- Responder side of the operation-controller interface.
- Holds a two-read/one-write register-file memory, operand registers, and an add/sub unit.
- Executes the RD_en1/RD_en2/WR_en1/mux1/mux2/arith_op strobes issued each cycle by the controller FSM.
- Produces read data, arithmetic results written back to memory, status flags and a sticky protocol-error bit.

Parameters:
- WIDTH, 8, data and memory word width in bits.
- DEPTH, 16, number of memory words.
- AW, $clog2(DEPTH), address width; derived, not overridden.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- RD_en1  input  1  port-1 read strobe.
- RD_en2  input  1  port-2 read strobe.
- WR_en1  input  1  port-1 write strobe.
- mux1  input  1  port-1 address select: 0 = rd_addr1, 1 = wr_addr.
- mux2  input  1  0 = plain memory op, 1 = arithmetic op. Selects the write-data source and the read destination.
- arith_op  input  1  0 = add, 1 = subtract (A - B).
- rd_addr1  input  AW  operand A / read address.
- rd_addr2  input  AW  operand B address.
- wr_addr  input  AW  write address.
- data_in  input  WIDTH  external write data.
- data_out  output  WIDTH  registered read data.
- out_valid  output  1  one-cycle pulse, data_out updated.
- carry  output  1  carry (add) or borrow (sub) from last arithmetic write-back.
- overflow  output  1  signed overflow from last arithmetic write-back.
- proto_err  output  1  sticky protocol-violation flag.

Behaviour:
- Reset (async): all memory words = 0. Operand registers A and B = 0. data_out = 0; out_valid, carry, overflow, proto_err = 0. Reset mid-operation abandons any pending arithmetic write.
- Port-1 address: addr1 = mux1 ? wr_addr : rd_addr1.
- Plain read (RD_en1=1, WR_en1=0, mux2=0):
  - data_out <= mem[addr1] at the edge; out_valid = 1 for exactly the following cycle. Latency is 1 cycle.
- Plain write (WR_en1=1, mux1=1, mux2=0): mem[wr_addr] <= data_in at the edge.
- Arithmetic read cycle (RD_en1=1, RD_en2=1, mux2=1):
  - A <= mem[addr1] and B <= mem[rd_addr2].
  - data_out and out_valid are unchanged.
- Arithmetic write-back cycle (WR_en1=1, mux1=1, mux2=1):
  - Result = A + B or A - B per arith_op, computed at WIDTH+1 bits.
  - mem[wr_addr] <= low WIDTH bits.
  - carry <= bit WIDTH. For subtract, carry = 1 means borrow (A < B unsigned).
  - overflow <= signed overflow of the WIDTH-bit two's-complement operation.
  - carry and overflow hold their value until the next write-back.
  - Operands come from registers, so a write-back targeting an operand address is safe.
- Write wraps modulo 2^WIDTH; no saturation.
- Port-2 read of the address written in the same cycle returns the old contents (read-before-write).
- Protocol violations. The offending operation is suppressed and proto_err <= 1 (sticky until reset):
  - RD_en1 and WR_en1 both high: port 1 is shared. The write proceeds, the read is suppressed, and the error is flagged.
  - WR_en1=1 with mux1=0: write suppressed.
  - RD_en2=1 with mux2=0: read ignored.
- Arithmetic write-back with no preceding arithmetic read since reset uses A = B = 0 and is not an error.
- All strobes low: hold. out_valid = 0.
- Addresses are always in range when DEPTH = 2^AW. If DEPTH is not a power of 2, out-of-range writes are dropped and out-of-range reads return 0.

Decomposition:
- Shared package csm_pkg:
  - opcode enum {OP_RD=2'b00, OP_WR=2'b01, OP_ADD=2'b10, OP_SUB=2'b11}, shared with the controller.
  - ARITH_ADD/ARITH_SUB constants.
  - Default WIDTH/DEPTH.
- One sub-module: csm_addsub (combinational WIDTH-bit add/sub with carry/borrow and overflow). Memory and flags stay in the top.

Test Plan:
- Reset, then plain write 0x3C to addr 5, then plain read of addr 5 -> data_out = 0x3C with out_valid high for exactly 1 cycle, one cycle after the read strobe.
- Mem[1]=0x70, mem[2]=0x20; ADD read (rd_addr1=1, rd_addr2=2) then write-back to addr 3 -> mem[3] = 0x90, carry = 0, overflow = 1.
- Mem[1]=0x05, mem[2]=0x07; SUB then write-back to addr 1 -> mem[1] = 0xFE, carry (borrow) = 1, overflow = 0. Later read of addr 1 returns 0xFE.
- Mem[4]=0xFF, mem[6]=0x01; ADD with write-back to addr 4 -> mem[4] = 0x00, carry = 1, overflow = 0.
- RD_en1 and WR_en1 together (mux1=1, data_in=0xAA, wr_addr=7) -> mem[7] = 0xAA, no out_valid, proto_err = 1 and stays 1 until rst_n is asserted.
- Assert rst_n low between the arithmetic read and write-back cycles -> memory all zero, flags 0, no write-back after reset release.
